// File: rtl/bus_transfer_ctrl.sv
// Register-transfer controller wrapped around an external 2:1 DA/BUS multiplexer.
// Handshaked LOAD / MOVE / SWAP / CLEAR commands write a 4-entry register bank from mux_out.
module bus_transfer_ctrl #(
    parameter int WORD_LENGTH = 8,
    parameter int NUM_REGS    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [1:0]             cmd_src,
    input  logic [1:0]             cmd_dst,
    output logic                   Sel_A,
    output logic [WORD_LENGTH-1:0] BUS,
    input  logic [WORD_LENGTH-1:0] mux_out,
    output logic                   done,
    input  logic [1:0]             rd_addr,
    output logic [WORD_LENGTH-1:0] rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_X1,
        ST_X2,
        ST_X3,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t                 state_reg, state_next;
    logic [1:0]             op_reg, src_reg, dst_reg;
    logic [WORD_LENGTH-1:0] tmp_reg;
    logic [WORD_LENGTH-1:0] regs_reg [NUM_REGS];

    logic                   wr_en;
    logic [1:0]             wr_addr;
    logic                   tmp_en;
    logic [NUM_REGS-1:0]    wr_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            tmp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && cmd_valid) begin
                op_reg  <= cmd_op;
                src_reg <= cmd_src;
                dst_reg <= cmd_dst;
            end
            if (tmp_en) begin
                tmp_reg <= mux_out;
            end
        end
    end

    // Every register write takes mux_out; the FSM only chooses what goes onto BUS.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        Sel_A      = 1'b0;
        BUS        = '0;
        wr_en      = 1'b0;
        wr_addr    = dst_reg;
        tmp_en     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ST_X1;
                end
            end
            ST_X1: begin
                unique case (op_reg)
                    OP_LOAD: begin
                        wr_en      = 1'b1;
                        state_next = ST_DONE;
                    end
                    OP_MOVE: begin
                        Sel_A      = 1'b1;
                        BUS        = regs_reg[src_reg];
                        wr_en      = 1'b1;
                        state_next = ST_DONE;
                    end
                    OP_SWAP: begin
                        Sel_A      = 1'b1;
                        BUS        = regs_reg[src_reg];
                        tmp_en     = 1'b1;
                        state_next = ST_X2;
                    end
                    OP_CLEAR: begin
                        Sel_A      = 1'b1;
                        wr_en      = 1'b1;
                        state_next = ST_DONE;
                    end
                    default: state_next = ST_DONE;
                endcase
            end
            ST_X2: begin
                Sel_A      = 1'b1;
                BUS        = regs_reg[dst_reg];
                wr_en      = 1'b1;
                wr_addr    = src_reg;
                state_next = ST_X3;
            end
            ST_X3: begin
                Sel_A      = 1'b1;
                BUS        = tmp_reg;
                wr_en      = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                regs_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                regs_reg[i] <= mux_out;
            end
        end
    end

    assign rd_data = regs_reg[rd_addr];

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl with a behavioural 2:1 DA/BUS multiplexer.
module tb_bus_transfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op, cmd_src, cmd_dst;
    logic       Sel_A;
    logic [7:0] BUS;
    logic [7:0] mux_out;
    logic [7:0] da;
    logic       done;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_out = Sel_A ? BUS : da;

    bus_transfer_ctrl #(.WORD_LENGTH(8), .NUM_REGS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .Sel_A     (Sel_A),
        .BUS       (BUS),
        .mux_out   (mux_out),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        #1;
        check(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command in IDLE; returns at the negedge inside X1 with cmd_valid dropped.
    task automatic accept(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] dst, input logic [7:0] val);
        da = val;
        accept(2'b00, 2'b00, dst);
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_src   = 2'b00;
        cmd_dst   = 2'b00;
        da        = 8'h00;
        rd_addr   = 2'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", {31'h0, cmd_ready}, 32'd1);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_sel", {31'h0, Sel_A}, 32'd0);
        check("rst_bus", {24'h0, BUS}, 32'h0);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

        // LOAD dst=2 with DA=0xA5
        da = 8'hA5;
        accept(2'b00, 2'b00, 2'd2);
        check("load_x1_sel", {31'h0, Sel_A}, 32'd0);
        check("load_x1_ready", {31'h0, cmd_ready}, 32'd0);
        check("load_x1_done", {31'h0, done}, 32'd0);
        tick();
        check("load_done", {31'h0, done}, 32'd1);
        check_reg("load_r2", 2'd2, 8'hA5);
        tick();
        check("load_done_end", {31'h0, done}, 32'd0);
        check("load_ready_back", {31'h0, cmd_ready}, 32'd1);

        // MOVE src=2 dst=0
        da = 8'h00;
        accept(2'b01, 2'd2, 2'd0);
        check("move_x1_sel", {31'h0, Sel_A}, 32'd1);
        check("move_x1_bus", {24'h0, BUS}, 32'hA5);
        tick();
        check("move_done", {31'h0, done}, 32'd1);
        check_reg("move_r0", 2'd0, 8'hA5);
        check_reg("move_r2", 2'd2, 8'hA5);
        tick();

        // SWAP src=1 dst=3
        load(2'd1, 8'h3C);
        load(2'd3, 8'hC3);
        da = 8'h00;
        accept(2'b10, 2'd1, 2'd3);
        check("swap_x1_sel", {31'h0, Sel_A}, 32'd1);
        check("swap_x1_bus", {24'h0, BUS}, 32'h3C);
        tick();
        check("swap_x2_bus", {24'h0, BUS}, 32'hC3);
        check("swap_x2_done", {31'h0, done}, 32'd0);
        tick();
        check("swap_x3_bus", {24'h0, BUS}, 32'h3C);
        check_reg("swap_r1_mid", 2'd1, 8'hC3);
        tick();
        check("swap_done", {31'h0, done}, 32'd1);
        check_reg("swap_r1", 2'd1, 8'hC3);
        check_reg("swap_r3", 2'd3, 8'h3C);
        tick();
        check("swap_ready_back", {31'h0, cmd_ready}, 32'd1);

        // CLEAR dst=0 with R0=0xFF
        load(2'd0, 8'hFF);
        check_reg("clr_pre_r0", 2'd0, 8'hFF);
        da = 8'h55;
        accept(2'b11, 2'd2, 2'd0);
        check("clr_x1_sel", {31'h0, Sel_A}, 32'd1);
        check("clr_x1_bus", {24'h0, BUS}, 32'h00);
        tick();
        check_reg("clr_r0", 2'd0, 8'h00);
        tick();

        // SWAP src=dst=1 keeps value, full latency
        load(2'd1, 8'h77);
        accept(2'b10, 2'd1, 2'd1);
        check("sswap_x1_done", {31'h0, done}, 32'd0);
        tick();
        check("sswap_x2_done", {31'h0, done}, 32'd0);
        tick();
        check("sswap_x3_done", {31'h0, done}, 32'd0);
        tick();
        check("sswap_done", {31'h0, done}, 32'd1);
        check_reg("sswap_r1", 2'd1, 8'h77);
        tick();

        // Back-to-back with cmd_valid held: LOAD dst=1 then MOVE 1->2
        da        = 8'h5A;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_src   = 2'd0;
        cmd_dst   = 2'd1;
        tick();
        cmd_op  = 2'b01;
        cmd_src = 2'd1;
        cmd_dst = 2'd2;
        check("b2b_x1_sel", {31'h0, Sel_A}, 32'd0);
        check("b2b_x1_ready", {31'h0, cmd_ready}, 32'd0);
        tick();
        check_reg("b2b_r1", 2'd1, 8'h5A);
        check("b2b_done_ready", {31'h0, cmd_ready}, 32'd0);
        tick();
        check("b2b_idle_ready", {31'h0, cmd_ready}, 32'd1);
        tick();
        check("b2b_mv_sel", {31'h0, Sel_A}, 32'd1);
        check("b2b_mv_bus", {24'h0, BUS}, 32'h5A);
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_dst   = 2'd1;
        tick();
        check_reg("b2b_r2", 2'd2, 8'h5A);
        check_reg("b2b_r1_kept", 2'd1, 8'h5A);
        tick();

        // Reset during X2 of a SWAP
        load(2'd0, 8'h11);
        load(2'd1, 8'h22);
        accept(2'b10, 2'd0, 2'd1);
        tick();
        check("rsw_x2_bus", {24'h0, BUS}, 32'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rsw_ready", {31'h0, cmd_ready}, 32'd1);
        check("rsw_done", {31'h0, done}, 32'd0);
        check("rsw_sel", {31'h0, Sel_A}, 32'd0);
        check("rsw_bus", {24'h0, BUS}, 32'h0);
        for (int i = 0; i < 4; i++) check_reg("rsw_reg", 2'(i), 8'h00);
        da = 8'h99;
        accept(2'b00, 2'd0, 2'd3);
        check("rsw_accept_x1", {31'h0, cmd_ready}, 32'd0);
        check("rsw_x1_done", {31'h0, done}, 32'd0);
        tick();
        check("rsw_load_done", {31'h0, done}, 32'd1);
        check_reg("rsw_r3", 2'd3, 8'h99);
        check_reg("rsw_r0", 2'd0, 8'h00);
        check_reg("rsw_r1", 2'd1, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
